piso_tx: RTL

//  Parallel-in/serial-out transmitter: accepts an n-bit word via valid/ready, shifts it out one bit per

---
 rtl/piso_tx_pkg.sv | 19 +
 rtl/piso_tx_if.sv | 26 ++
 rtl/piso_shreg.sv | 47 ++++
 rtl/piso_tx.sv | 107 ++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types for the piso_tx serial transmitter: state encoding and frame length.
// Optional macro PISO_TX_PARITY_EN appends one even-parity bit to every frame.
package piso_tx_pkg;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } state_e;

    // Bits per frame: data word plus the optional parity bit.
    function automatic int frame_len(input int n);
`ifdef PISO_TX_PARITY_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle of piso_tx.
// master: word source / bit consumer; slave: the transmitter.
interface piso_tx_if #(
    parameter int N = 8
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         shift_en;
    logic         sout;
    logic         sout_valid;
    logic         frame_first;
    logic         frame_last;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, sout, sout_valid,
        input  frame_first, frame_last
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, sout, sout_valid,
        output frame_first, frame_last
    );
endinterface

// File: rtl/piso_shreg.sv
// N-bit shift register with per-bit load/shift/hold mux and async clear.
// Ports: clk, rst_n, load (parallel load), shift (advance one bit), din, head (bit on the wire).
module piso_shreg #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         head
);
    logic [N-1:0] bits_q;
    logic [N-1:0] bits_d;
    logic [N-1:0] shifted;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {bits_q[N-2:0], 1'b0};
        end else begin
            shifted = {1'b0, bits_q[N-1:1]};
        end
    end

    // Each bit behaves like an enable-gated D flop; load wins over shift.
    always_comb begin
        bits_d = bits_q;
        for (int i = 0; i < N; i++) begin
            if (load) begin
                bits_d[i] = din[i];
            end else if (shift) begin
                bits_d[i] = shifted[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign head = MSB_FIRST ? bits_q[N-1] : bits_q[0];
endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with frame markers and stall support.
// Ports: clk, rst_n, bus (piso_tx_if.slave). Macro PISO_TX_PARITY_EN adds even parity.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int n         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    piso_tx_if.slave   bus
);
    localparam int FRAME_LEN = frame_len(n);
    localparam int CW        = $clog2(n + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic is_shift;
    logic at_first;
    logic at_last;
    logic consume;
    logic ready;
    logic accept;
    logic head_bit;
    logic tx_bit;

    assign is_shift = (state_q == PISO_SHIFT);
    assign at_first = is_shift && (cnt_q == '0);
    assign at_last  = is_shift && (cnt_q == LAST_CNT);
    assign consume  = is_shift && bus.shift_en;
    // Reopen on the edge that consumes the last bit so frames abut.
    assign ready    = !is_shift || (at_last && bus.shift_en);
    assign accept   = bus.load_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = PISO_SHIFT;
            cnt_d   = '0;
        end else if (consume) begin
            if (at_last) begin
                state_d = PISO_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PISO_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shreg #(
        .N         (n),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (consume && !accept),
        .din   (bus.load_data),
        .head  (head_bit)
    );

`ifdef PISO_TX_PARITY_EN
    logic par_q;
    logic par_d;

    // Latched at accept so later load_data changes cannot alter it.
    always_comb begin
        par_d = par_q;
        if (accept) begin
            par_d = ^bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign tx_bit = (cnt_q == CW'(n)) ? par_q : head_bit;
`else
    assign tx_bit = head_bit;
`endif

    assign bus.load_ready  = ready;
    assign bus.sout        = is_shift && tx_bit;
    assign bus.sout_valid  = is_shift;
    assign bus.frame_first = at_first;
    assign bus.frame_last  = at_last;
endmodule
